// File: rtl/uart_defs_pkg.sv
// uart_defs: definitions shared by the UART transmitter and any future
// receiver. It holds the state encoding, the data width and the DIV
// rounding formula, so that both directions derive identical bit timing.
package uart_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;

    // Clocks per bit, rounded to the nearest integer.
    // Residual error: |DIV*BAUD - CLK_HZ| <= BAUD/2.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the frame sequencer and the
// transmitter, plus the serial line.
//   tx_data  : byte to send, sampled only on the accept cycle
//   tx_start : level request, held by the producer until it sees tx_busy
//   tx_busy  : transmitter is sending a frame
//   txd      : serial line, idle high
// Modports: master = producer side, slave = transmitter side.
interface uart_tx_if;
    import uart_defs::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic                      txd;

    modport master (output tx_data, output tx_start, input tx_busy, input txd);
    modport slave  (input tx_data, input tx_start, output tx_busy, output txd);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter.
//   clk, rst_n : clock, async active-low reset
//   restart    : synchronous clear; the count is 0 on the cycle after it
//   tick       : high for one cycle while the count is DIV-1 (bit boundary)
module uart_baud_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (restart || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 asynchronous serial transmitter.
//   clk, rst_n : clock, async active-low reset (aborts a frame immediately)
//   bus        : uart_tx_if.slave (tx_data, tx_start in; tx_busy, txd out)
// A byte is accepted when the FSM is idle, tx_start is high and the request
// is armed. The request is armed by any cycle with tx_start low, so a request
// held high across the end of a frame does not resend the same byte.
// txd and tx_busy are registered from the next-state values, so the start
// bit and busy both appear on the edge that accepts the byte.
module uart_tx
    import uart_defs::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);
    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx: DIV = %0d, must be >= 2", DIV);
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
        $error("uart_tx: STOP_BITS = %0d, must be 1 or 2", STOP_BITS);
    end

    uart_state_e               state, state_nxt;
    logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
    logic [2:0]                bit_cnt, bit_cnt_nxt;
    logic                      armed;
    logic                      accept;
    logic                      tick;
    logic                      txd_q, txd_nxt;
    logic                      busy_q, busy_nxt;

    assign accept = (state == IDLE) && bus.tx_start && armed;

    // Holding the counter in reset while idle makes every frame start at
    // count 0; later state changes land on the wrap, which also clears it.
    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state == IDLE),
        .tick    (tick)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            armed   <= 1'b1;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            txd_q   <= txd_nxt;
            busy_q  <= busy_nxt;
            if (!bus.tx_start)
                armed <= 1'b1;
            else if (accept)
                armed <= 1'b0;
        end
    end

    // Next state, shift register and bit counter
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = START;
                    shreg_nxt   = bus.tx_data;
                    bit_cnt_nxt = '0;
                end
            end
            START: begin
                if (tick)
                    state_nxt = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_nxt = {1'b0, shreg[UART_DATA_BITS-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt   = STOP;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_nxt   = IDLE;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line level for the state being entered; registered above.
    always_comb begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b1;
        case (state_nxt)
            IDLE:    busy_nxt = 1'b0;
            START:   txd_nxt  = 1'b0;
            DATA:    txd_nxt  = shreg_nxt[0];
            STOP:    txd_nxt  = 1'b1;
            default: busy_nxt = 1'b0;
        endcase
    end

    assign bus.txd     = txd_q;
    assign bus.tx_busy = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at CLK_HZ=80, BAUD=10 (DIV=8).
// dut1 uses one stop bit, dut2 uses two. The producer pushes each requested
// byte into a per-DUT queue; a monitor per DUT watches the line, decodes each
// frame from its bit-level shape and compares it with the queue head.
module tb_uart_tx;
    import uart_defs::*;

    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if bus1();
    uart_tx_if bus2();

    uart_tx #(.CLK_HZ(80), .BAUD(10), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    uart_tx #(.CLK_HZ(80), .BAUD(10), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    int frames[2];
    int busy_cnt[2];
    int sent[2];
    int aborted[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_busy(input int k);
        return (k == 0) ? bus1.tx_busy : bus2.tx_busy;
    endfunction

    function automatic logic get_txd(input int k);
        return (k == 0) ? bus1.txd : bus2.txd;
    endfunction

    task automatic set_req(input int k, input logic s, input logic [7:0] d);
        if (k == 0) begin
            bus1.tx_start = s;
            bus1.tx_data  = d;
        end else begin
            bus2.tx_start = s;
            bus2.tx_data  = d;
        end
    endtask

    task automatic push_exp(input int k, input logic [7:0] d);
        if (k == 0) exp_q1.push_back(d);
        else        exp_q2.push_back(d);
        sent[k]++;
    endtask

    task automatic pop_exp(input int k, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        if (k == 0 && exp_q1.size() > 0) begin d = exp_q1.pop_front(); ok = 1'b1; end
        if (k == 1 && exp_q2.size() > 0) begin d = exp_q2.pop_front(); ok = 1'b1; end
    endtask

    always @(negedge clk) begin
        if (bus1.tx_busy === 1'b1) busy_cnt[0]++;
        if (bus2.tx_busy === 1'b1) busy_cnt[1]++;
    end

    // Monitor: a frame is 1 start + 8 data + sb stop bits, each exactly DIV
    // clocks, busy high throughout and low on the clock after the last stop.
    task automatic monitor(input int k);
        int sb, n, errs, b;
        logic lvl;
        logic [7:0] got, exp;
        bit have, abort;
        sb = (k == 0) ? 1 : 2;
        n  = (1 + 8 + sb) * DIV;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || get_txd(k) !== 1'b0) continue;
            pop_exp(k, exp, have);
            check($sformatf("frame_expected[%0d]", k), int'(have), 1);
            errs  = 0;
            abort = 1'b0;
            got   = '0;
            lvl   = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(negedge clk);
                if (rst_n !== 1'b1) begin abort = 1'b1; break; end
                b = i / DIV;
                if (i % DIV == 0) lvl = get_txd(k);
                if (get_txd(k) !== lvl) errs++;
                if (get_busy(k) !== 1'b1) errs++;
                if (b == 0 && lvl !== 1'b0) errs++;
                if (b >= 9 && lvl !== 1'b1) errs++;
                if (b >= 1 && b <= 8) got[b-1] = lvl;
            end
            if (abort) continue;
            check($sformatf("frame_shape[%0d]", k), errs, 0);
            if (have) check($sformatf("frame_byte[%0d]", k), int'(got), int'(exp));
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check($sformatf("busy_end[%0d]", k), int'(get_busy(k)), 0);
                check($sformatf("idle_txd[%0d]", k), int'(get_txd(k)), 1);
            end
            frames[k]++;
        end
    endtask

    // Wait (at negedges) until busy equals lvl; n = negedges waited.
    task automatic wait_busy(input int k, input logic lvl, input int bound,
                             input string name, output int n);
        n = 0;
        while (get_busy(k) !== lvl && n <= bound) begin
            @(negedge clk);
            n++;
        end
        if (n > bound) check({name, "_timeout"}, n, bound);
    endtask

    // Called just after a negedge; returns once busy has fallen again.
    task automatic send(input int k, input logic [7:0] d, output int lat);
        int dn;
        set_req(k, 1'b1, d);
        push_exp(k, d);
        wait_busy(k, 1'b1, 20, "busy_rise", lat);
        set_req(k, 1'b0, d);
        wait_busy(k, 1'b0, 200, "busy_fall", dn);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b0, f0, cnt, dn;
        logic [7:0] burst[11];
        logic [7:0] sum;

        set_req(0, 1'b0, 8'h00);
        set_req(1, 1'b0, 8'h00);
        fork
            monitor(0);
            monitor(1);
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd1", int'(bus1.txd), 1);
        check("rst_busy1", int'(bus1.tx_busy), 0);
        check("rst_txd2", int'(bus2.txd), 1);
        check("rst_busy2", int'(bus2.tx_busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy1", int'(bus1.tx_busy), 0);

        // Single byte 0x5A: busy for exactly 10 bits
        b0 = busy_cnt[0];
        send(0, 8'h5A, lat);
        check("single_lat", lat, 1);
        check("single_busy_clks", busy_cnt[0] - b0, 80);

        // Sequencer burst: header, nine data bytes, checksum
        burst[0] = 8'h5A;
        sum = '0;
        for (int i = 1; i <= 9; i++) begin
            burst[i] = 8'($urandom);
            sum += burst[i];
        end
        burst[10] = sum;
        repeat (3) @(negedge clk);
        b0 = busy_cnt[0];
        f0 = frames[0];
        for (int i = 0; i < 11; i++) begin
            send(0, burst[i], lat);
            check($sformatf("burst_gap[%0d]", i), lat, 1);
        end
        check("burst_busy_clks", busy_cnt[0] - b0, 880);
        repeat (2) @(negedge clk);
        check("burst_frames", frames[0] - f0, 11);

        // tx_start held high: exactly one frame
        f0 = frames[0];
        set_req(0, 1'b1, 8'hA5);
        push_exp(0, 8'hA5);
        wait_busy(0, 1'b1, 20, "hold_rise", lat);
        wait_busy(0, 1'b0, 200, "hold_fall", dn);
        b0 = busy_cnt[0];
        repeat (100) @(negedge clk);
        check("hold_no_resend", busy_cnt[0] - b0, 0);
        check("hold_frames", frames[0] - f0, 1);
        set_req(0, 1'b0, 8'hA5);
        @(negedge clk);
        send(0, 8'h3C, lat);
        check("rearm_lat", lat, 1);

        // tx_data changes after accept have no effect
        repeat (2) @(negedge clk);
        set_req(0, 1'b1, 8'h0F);
        push_exp(0, 8'h0F);
        wait_busy(0, 1'b1, 20, "dchg_rise", lat);
        repeat (2) @(negedge clk);
        set_req(0, 1'b1, 8'hF0);
        @(negedge clk);
        set_req(0, 1'b0, 8'hF0);
        wait_busy(0, 1'b0, 200, "dchg_fall", dn);

        // Two stop bits, 0xFF
        repeat (2) @(negedge clk);
        b0 = busy_cnt[1];
        send(1, 8'hFF, lat);
        check("stop2_lat", lat, 1);
        check("stop2_busy_clks", busy_cnt[1] - b0, 88);

        // Random bytes on both DUTs
        for (int i = 0; i < 6; i++) begin
            send(0, 8'($urandom), lat);
            send(1, 8'($urandom), lat);
        end

        // Reset in the middle of a 0x00 frame
        repeat (2) @(negedge clk);
        send_start:
        begin
            set_req(0, 1'b1, 8'h00);
            push_exp(0, 8'h00);
            wait_busy(0, 1'b1, 20, "rstmid_rise", lat);
            set_req(0, 1'b0, 8'h00);
        end
        repeat (36) @(negedge clk);
        #2 rst_n = 1'b0;
        aborted[0]++;
        #1;
        check("rstmid_txd", int'(bus1.txd), 1);
        check("rstmid_busy", int'(bus1.tx_busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b0 = busy_cnt[0];
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus1.txd !== 1'b1) cnt++;
        end
        check("rstmid_idle_busy", busy_cnt[0] - b0, 0);
        check("rstmid_idle_txd_low", cnt, 0);
        send(0, 8'hC3, lat);
        check("post_rst_lat", lat, 1);

        // Scoreboard drained, every non-aborted frame seen
        repeat (20) @(negedge clk);
        check("queue1_empty", exp_q1.size(), 0);
        check("queue2_empty", exp_q2.size(), 0);
        check("frames1", frames[0], sent[0] - aborted[0]);
        check("frames2", frames[1], sent[1] - aborted[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
